// File: rtl/posit_decoder_pipe_pkg.sv
// Shared posit decoder definitions: default format, derived field widths
// and the special-value classification carried down the pipeline.
package posit_decoder_pipe_pkg;

  localparam int POSIT_N_DEF  = 16;
  localparam int POSIT_ES_DEF = 1;

  // Special-value class, resolved in the first stage so later stages only
  // need to force fields instead of re-inspecting the word.
  typedef enum logic [1:0] {
    PC_NORMAL = 2'd0,
    PC_ZERO   = 2'd1,
    PC_NAR    = 2'd2
  } pclass_e;

  // Signed regime width: k spans -(N-1) .. N-2.
  function automatic int posit_rs(input int n);
    return $clog2(n) + 1;
  endfunction

  // Fraction width with the hidden bit excluded.
  function automatic int posit_fs(input int n, input int es);
    return n - es - 3;
  endfunction

endpackage

// File: rtl/posit_run_detect.sv
// Combinational leading-run detector: length of the run of bits equal to
// the MSB (always >= 1) plus all-ones / all-zeros flags.
module posit_run_detect #(
  parameter int W = 15
) (
  input  logic [W-1:0]               vec_i,
  output logic [$clog2(W+1)-1:0]     run_o,
  output logic                       allone_o,
  output logic                       allzero_o
);

  localparam int RW = $clog2(W + 1);

  assign allone_o  = &vec_i;
  assign allzero_o = ~|vec_i;

  // Walk down from the MSB, counting until the first bit that differs.
  always_comb begin
    logic cont;
    run_o = RW'(1);
    cont  = 1'b1;
    for (int i = W - 2; i >= 0; i--) begin
      if (cont && (vec_i[i] == vec_i[W-1])) run_o = run_o + RW'(1);
      else                                  cont  = 1'b0;
    end
  end

endmodule

// File: rtl/posit_decoder_pipe.sv
// Three-stage streaming posit decoder with valid/ready on both sides.
// S1: sign + two's-complement body, S2: regime run, S3: exp/frac split.
module posit_decoder_pipe
  import posit_decoder_pipe_pkg::*;
#(
  parameter int N  = POSIT_N_DEF,
  parameter int ES = POSIT_ES_DEF,
  parameter int RS = posit_rs(N),
  parameter int FS = posit_fs(N, ES),
  localparam int EW = (ES > 0) ? ES : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [RS-1:0] out_k,
  output logic [EW-1:0] out_exp,
  output logic [FS-1:0] out_frac,
  output logic          out_zero,
  output logic          out_nar
);

  localparam int RW = $clog2(N);

  // Valid bit of each stage; index = stage number.
  logic [3:1] vld_q;
  logic       en1, en2, en3;

  // A stage may load when it is empty or its content moves on this cycle.
  assign en3       = !vld_q[3] || out_ready;
  assign en2       = !vld_q[2] || en3;
  assign en1       = !vld_q[1] || en2;
  assign in_ready  = en1;
  assign out_valid = vld_q[3];

  // Valid shift register; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      if (en1) vld_q[1] <= in_valid;
      if (en2) vld_q[2] <= vld_q[1];
      if (en3) vld_q[3] <= vld_q[2];
    end
  end

  // ---------------- S1 ----------------
  logic [N-2:0] body_d, body1_q;
  logic         sign1_q;
  pclass_e      cls_d, cls1_q;

  // Negative posits decode from the two's complement of the low N-1 bits;
  // an all-zero body can only be zero or NaR.
  always_comb begin
    body_d = in_data[N-1] ? -in_data[N-2:0] : in_data[N-2:0];
    cls_d  = PC_NORMAL;
    if (~|body_d) cls_d = in_data[N-1] ? PC_NAR : PC_ZERO;
  end

  // Stage-1 payload register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign1_q <= 1'b0;
      body1_q <= '0;
      cls1_q  <= PC_NORMAL;
    end else if (en1 && in_valid) begin
      sign1_q <= in_data[N-1];
      body1_q <= body_d;
      cls1_q  <= cls_d;
    end
  end

  // ---------------- S2 ----------------
  logic [RW-1:0]  run, run_sat;
  logic           rd_allone, rd_allzero;
  logic [RS-1:0]  k_d, k2_q;
  logic [N-4:0]   rem_d, rem2_q;
  logic           sign2_q;
  pclass_e        cls2_q;

  posit_run_detect #(.W(N-1)) u_run (
    .vec_i     (body1_q),
    .run_o     (run),
    .allone_o  (rd_allone),
    .allzero_o (rd_allzero)
  );

  // Regime value and the bits left after the run and its terminator.
  // Shifting only the low N-3 bits by r-1 equals shifting the full body by
  // r+1 and dropping the two always-zero LSBs; a saturated run leaves 0.
  always_comb begin
    run_sat = (rd_allone || rd_allzero) ? RW'(N - 1) : run;
    k_d     = body1_q[N-2] ? (RS'(run_sat) - RS'(1)) : -RS'(run_sat);
    rem_d   = body1_q[N-4:0] << (run_sat - RW'(1));
  end

  // Stage-2 payload register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign2_q <= 1'b0;
      k2_q    <= '0;
      rem2_q  <= '0;
      cls2_q  <= PC_NORMAL;
    end else if (en2 && vld_q[1]) begin
      sign2_q <= sign1_q;
      k2_q    <= k_d;
      rem2_q  <= rem_d;
      cls2_q  <= cls1_q;
    end
  end

  // ---------------- S3 ----------------
  logic [EW-1:0] exp_d;
  logic [FS-1:0] frac_d;
  logic          normal;

  // Exponent is the top ES remaining bits, fraction the rest (MSB-aligned).
  always_comb begin
    frac_d = rem2_q[FS-1:0];
    exp_d  = '0;
    if (ES > 0) exp_d = rem2_q[N-4 -: EW];
  end

  assign normal = (cls2_q == PC_NORMAL);

  // Output registers; they only change when a new word is loaded, so a
  // stalled or empty output holds its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sign <= 1'b0;
      out_k    <= '0;
      out_exp  <= '0;
      out_frac <= '0;
      out_zero <= 1'b0;
      out_nar  <= 1'b0;
    end else if (en3 && vld_q[2]) begin
      out_sign <= (cls2_q == PC_NAR) || (normal && sign2_q);
      out_k    <= normal ? k2_q   : '0;
      out_exp  <= normal ? exp_d  : '0;
      out_frac <= normal ? frac_d : '0;
      out_zero <= (cls2_q == PC_ZERO);
      out_nar  <= (cls2_q == PC_NAR);
    end
  end

endmodule
